// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states, size mask.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (see load_store_unit.sv).
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // Unshifted byte mask for an access size code (funct3[1:0]).
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane aligner: store data steering / byte mask, and load
// extraction with sign or zero extension across a two-word window.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  output logic [63:0] wsteer_o,
  output logic [7:0]  mask_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift_s;
  logic [31:0] rshift_unused_s;

  assign mask_o   = {4'b0000, size_mask(funct3_i[1:0])} << offset_i;
  assign wsteer_o = {32'h0000_0000, wdata_i} << {offset_i, 3'b000};
  assign {rshift_unused_s, rshift_s} = {rdata1_i, rdata0_i} >> {offset_i, 3'b000};

  // Load result extension by width and signedness.
  always_comb begin
    case (funct3_i)
      F3_LB:   rdata_o = {{24{rshift_s[7]}}, rshift_s[7:0]};
      F3_LH:   rdata_o = {{16{rshift_s[15]}}, rshift_s[15:0]};
      F3_LW:   rdata_o = rshift_s;
      F3_LBU:  rdata_o = {24'h00_0000, rshift_s[7:0]};
      F3_LHU:  rdata_o = {16'h0000, rshift_s[15:0]};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-aligned, byte-enabled memory bus.
// Macro LSU_MISALIGNED_SPLIT_EN: split word-crossing accesses into two beats; otherwise they error.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic              req_ready_q;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              idle_s, illegal_s, misalign_s;
  logic [1:0]        cur_off_s;
  logic [2:0]        cur_f3_s;
  logic [31:0]       cur_wdata_s, rd0_s, rd1_s, ld_s;
  logic [63:0]       wsteer_s;
  logic [7:0]        mask_s;

  // While idle the aligner sees the incoming request; afterwards the captured copy.
  assign idle_s      = (state_q == ST_IDLE);
  assign cur_off_s   = idle_s ? req_addr[1:0] : off_q;
  assign cur_f3_s    = idle_s ? req_funct3    : f3_q;
  assign cur_wdata_s = idle_s ? req_wdata     : wdata_q;
  assign rd0_s       = (state_q == ST_WAIT0) ? mem_rdata : rdata0_q;

  assign illegal_s = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                  || (req_write && req_funct3[2]);

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] rdata1_q, rdata1_d;
  logic        split_s;
  assign rd1_s      = (state_q == ST_WAIT1) ? mem_rdata : rdata1_q;
  assign misalign_s = 1'b0;
  assign split_s    = (mask_s[7:4] != 4'b0000);
`else
  logic        unused_s;
  assign rd1_s      = 32'h0000_0000;
  assign misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign unused_s   = ^{mask_s[7:4], wsteer_s[63:32]};
`endif

  lsu_lane_align u_align (
    .offset_i (cur_off_s),
    .funct3_i (cur_f3_s),
    .wdata_i  (cur_wdata_s),
    .rdata0_i (rd0_s),
    .rdata1_i (rd1_s),
    .wsteer_o (wsteer_s),
    .mask_o   (mask_s),
    .rdata_o  (ld_s)
  );

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    rdata1_d     = rdata1_q;
`endif
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_write;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (illegal_s || misalign_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = ST_REQ0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = mask_s[3:0];
            mem_wdata_d = wsteer_s[31:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ0: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          state_d = ST_REQ0;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_s) begin
            state_d     = ST_REQ1;
            mem_req_d   = 1'b1;
            mem_we_d    = we_q;
            mem_addr_d  = mem_addr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
            mem_be_d    = mask_s[7:4];
            mem_wdata_d = wsteer_s[63:32];
          end else
`endif
          begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? 32'h0000_0000 : ld_s;
          end
        end else begin
          state_d = ST_WAIT0;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_REQ1: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          state_d = ST_REQ1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          rdata1_d     = mem_rdata;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0000_0000 : ld_s;
        end else begin
          state_d = ST_WAIT1;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      rdata0_q     <= 32'h0000_0000;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rdata1_q     <= 32'h0000_0000;
`endif
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rdata1_q     <= rdata1_d;
`endif
      req_ready_q  <= (state_d == ST_IDLE);
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected beats/responses are queued at issue,
// a memory model checks bus beats and a monitor checks responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_be;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } beat_t;
  typedef struct { logic [31:0] rdata; logic err; } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, resp_cyc = 0, t0 = 0;
  int gnt_dly = 1, rv_dly = 0;
  bit no_grant = 1'b0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: checks each beat, optionally stalls grant and response.
  initial begin
    int phase = 0, cnt = 0;
    bit fresh = 1'b0;
    beat_t e;
    logic [31:0] sa, sw;
    logic [3:0]  sb;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && mem_req) begin
          if (beat_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual_addr=%h required=no_bus_activity", mem_addr);
          end else begin
            e = beat_q.pop_front();
            check("beat_addr", mem_addr, e.addr);
            check("beat_be", {28'h0, mem_be}, {28'h0, e.be});
            check("beat_we", {31'h0, mem_we}, {31'h0, e.we});
            if (e.we) check("beat_wdata", mem_wdata, e.wdata);
          end
          sa = mem_addr; sb = mem_be; sw = mem_wdata;
          cnt = gnt_dly; phase = 1; fresh = 1'b1;
        end
        if (phase == 1) begin
          if (!fresh) begin
            check("stall_req", {31'h0, mem_req}, 32'h1);
            check("stall_addr", mem_addr, sa);
            check("stall_be", {28'h0, mem_be}, {28'h0, sb});
            check("stall_wdata", mem_wdata, sw);
          end
          fresh = 1'b0;
          if (!no_grant) begin
            if (cnt == 0) begin
              mem_gnt = 1'b1; phase = 2; cnt = rv_dly;
            end else cnt--;
          end
        end else if (phase == 2) begin
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            phase = 0;
          end else cnt--;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst && resp_valid) begin
        resp_cyc = cyc;
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual_rdata=%h err=%b required=none", resp_rdata, resp_err);
        end else begin
          r = resp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    t0 = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int nb, input logic [3:0] be0, input logic [3:0] be1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [31:0] rd0, input logic [31:0] rd1,
                     input logic [31:0] exp, input logic err);
    int n = 0;
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    if (nb >= 1) begin beat_q.push_back('{wa, be0, wd0, w}); rd_q.push_back(rd0); end
    if (nb == 2) begin beat_q.push_back('{wa + 32'd4, be1, wd1, w}); rd_q.push_back(rd1); end
    resp_q.push_back('{exp, err});
    issue(w, f3, a, wd);
    while ((resp_q.size() != 0 || beat_q.size() != 0) && n < 80) begin @(negedge clk); n++; end
    check("pending_resp", resp_q.size(), 32'd0);
    check("pending_beat", beat_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b1;

    //  w     f3      addr           wdata         nb be0     be1     wd0            wd1           rd0            rd1            expected       err
    run(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 1, 4'b0100, 4'b0000, 32'h00A5_0000, 32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b0);
    run(1'b0, 3'b000, 32'h0000_0203, 32'h0,         1, 4'b1000, 4'b0000, 32'h0,         32'h0,        32'h8012_3456, 32'h0,         32'hFFFF_FF80, 1'b0);
    run(1'b0, 3'b100, 32'h0000_0203, 32'h0,         1, 4'b1000, 4'b0000, 32'h0,         32'h0,        32'h8012_3456, 32'h0,         32'h0000_0080, 1'b0);
    run(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1, 4'b1111, 4'b0000, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b0);
    run(1'b0, 3'b010, 32'h0000_0020, 32'h0,         1, 4'b1111, 4'b0000, 32'h0,         32'h0,        32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0);
    check("aligned_latency", resp_cyc - t0, 32'd4);
    run(1'b0, 3'b001, 32'h0000_0022, 32'h0,         1, 4'b1100, 4'b0000, 32'h0,         32'h0,        32'h8001_7FFF, 32'h0,         32'hFFFF_8001, 1'b0);
    run(1'b0, 3'b101, 32'h0000_0022, 32'h0,         1, 4'b1100, 4'b0000, 32'h0,         32'h0,        32'h8001_7FFF, 32'h0,         32'h0000_8001, 1'b0);
    run(1'b1, 3'b001, 32'h0000_0042, 32'h0000_BABE, 1, 4'b1100, 4'b0000, 32'hBABE_0000, 32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b0);
    run(1'b0, 3'b011, 32'h0000_0030, 32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
    run(1'b1, 3'b100, 32'h0000_0030, 32'h0000_0055, 0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
    run(1'b0, 3'b110, 32'h0000_0030, 32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    run(1'b0, 3'b001, 32'h0000_0051, 32'h0,         1, 4'b0110, 4'b0000, 32'h0,         32'h0,        32'h00AB_CD00, 32'h0,         32'hFFFF_ABCD, 1'b0);
    run(1'b0, 3'b010, 32'h0000_0302, 32'h0,         2, 4'b1100, 4'b0011, 32'h0,         32'h0,        32'hBBAA_1122, 32'h3344_CCDD, 32'hCCDD_BBAA, 1'b0);
    run(1'b1, 3'b001, 32'h0000_03FF, 32'h0000_1234, 2, 4'b1000, 4'b0001, 32'h3400_0000, 32'h0000_0012, 32'h0,       32'h0,         32'h0000_0000, 1'b0);
    run(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0,         2, 4'b1000, 4'b0001, 32'h0,         32'h0,        32'hAB00_0000, 32'h0000_00CD, 32'h0000_CDAB, 1'b0);
`else
    run(1'b0, 3'b001, 32'h0000_0051, 32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
    run(1'b0, 3'b010, 32'h0000_0302, 32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
    run(1'b1, 3'b001, 32'h0000_03FF, 32'h0000_1234, 0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
    run(1'b1, 3'b010, 32'h0000_0022, 32'h1111_2222, 0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b1);
`endif

    gnt_dly = 5; rv_dly = 3;
    run(1'b1, 3'b010, 32'h0000_0060, 32'h1122_3344, 1, 4'b1111, 4'b0000, 32'h1122_3344, 32'h0,        32'h0,         32'h0,         32'h0000_0000, 1'b0);
    gnt_dly = 1; rv_dly = 0;

    // Reset while a request is waiting for grant: abandoned, no response.
    no_grant = 1'b1;
    beat_q.push_back('{32'h0000_0500, 4'b1111, 32'h0, 1'b0});
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("async_rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    no_grant = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_pending_beat", beat_q.size(), 32'd0);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory path: accepts one load/store per handshake from the CPU execute stage and drives a word-aligned, byte-enabled memory request/response bus.
- Performs all byte lane steering, byte-enable generation, load extraction and sign/zero extension for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Misaligned accesses that cross a word boundary are split into two aligned word transactions when the optional feature is compiled in.

Parameters:
- ADDR_W, 32, byte address width; memory address outputs are word-aligned, so bits [1:0] are always 0.

Ports:
- clk  in  1  clock; all state on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  with resp_valid: illegal funct3, or misaligned access when the feature is off
- mem_req  out  1  memory request; held until granted
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered write data
- mem_rvalid  in  1  response for the oldest granted request; pulses for stores too
- mem_rdata  in  32  raw read word

Behaviour:
- Reset (rst low, asynchronous) forces:
  - FSM to IDLE.
  - req_ready = 1.
  - resp_valid, resp_err, mem_req, mem_we = 0.
  - mem_addr, mem_be, mem_wdata, resp_rdata = 0.
  - All captured request state is cleared.
- Reset mid-transaction abandons the transaction and produces no response.
- Request capture:
  - On req_valid & req_ready, register write, funct3, addr and wdata.
  - Compute offset o = addr[1:0] and size s: 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
- Illegal requests:
  - Illegal funct3 is 011, 11x, or any store with funct3[2]=1.
  - Go to RESP with resp_err=1; no bus activity.
- Lane mask and data steering:
  - m = ((1<<s)-1) << o, 8 bits wide.
  - 64-bit steered data = wdata << (8*o).
  - Beat 0 uses mem_be = m[3:0], mem_wdata = steered[31:0], mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Beat 1 (only when m[7:4] != 0) uses mem_be = m[7:4], mem_wdata = steered[63:32], mem_addr = beat-0 address + 4, wrapping modulo 2^ADDR_W.
  - Loads drive mem_be = m as well, but the memory may return the full word.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE -> REQ0 on accept.
  - REQ0: mem_req=1 until mem_gnt, then WAIT0.
  - WAIT0: on mem_rvalid, latch rdata0. Go to REQ1 if split, else RESP.
  - REQ1/WAIT1: same pattern for beat 1, latching rdata1.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Load merge:
  - Form {rdata1, rdata0} >> (8*o); use bits [8s-1:0].
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- Latency:
  - Aligned, with mem_gnt the cycle after request and mem_rvalid the cycle after grant: accept at cycle 0, resp_valid at cycle 4.
  - A split access adds 2 cycles minimum.
- mem_rvalid handling: one outstanding beat at a time; mem_rvalid outside WAIT0/WAIT1 is ignored.
- mem_gnt and mem_rvalid in the same cycle while in REQ0: the grant is taken; the rvalid is ignored.
- Outputs are registered; no combinational path from req_* to mem_*.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: word-crossing accesses use the two-beat sequence above. A non-crossing misaligned access (e.g. LH at offset 1) completes in one beat.
- Undefined: any misaligned access errors, i.e. LH/LHU/SH with o odd, or LW/SW with o != 0. It goes straight to RESP with resp_err=1 and no bus activity; REQ1/WAIT1 are not built.

Decomposition:
- Shared package: funct3 encodings (LB..LHU, SB..SW), FSM state enum, size/mask helper constants.
- One sub-module, lsu_lane_align: purely combinational.
  - Store direction: offset/size/wdata -> 64-bit steered data plus 8-bit mask.
  - Load direction: {rdata1,rdata0}/offset/funct3 -> extended result.
  - Shared by store and load paths.

Test Plan:
- Reset: assert rst low mid-REQ0 -> mem_req=0 and req_ready=1 immediately (asynchronously); no resp_valid afterwards.
- SB: addr=0x102, wdata=0xA5 -> one beat, mem_addr=0x100, mem_be=0100, mem_wdata=0x00A50000; resp_valid with resp_rdata=0.
- LB/LBU: addr=0x203, mem_rdata=0x80xxxxxx -> LB resp_rdata=0xFFFFFF80; LBU resp_rdata=0x00000080.
- Split LW (feature on): addr=0x302, beat0 rdata=0xBBAA1122, beat1 rdata=0x3344CCDD.
  - Expect beats to 0x300 (be=1100) and 0x304 (be=0011).
  - Expect resp_rdata=0xCCDDBBAA.
- Split SH (feature on) at 0x3FF: beats 0x3FC be=1000 and 0x400 be=0001; with the feature off, resp_err=1 and mem_req never asserted.
- Stalls and illegal funct3:
  - mem_gnt held low 5 cycles, then mem_rvalid delayed 3 cycles -> mem_req stays high with stable mem_addr/mem_be/mem_wdata; resp_valid exactly once.
  - funct3=011 -> resp_err=1, no bus activity.
